// File: rtl/mem_op_sequencer.sv
// Purpose : sequences RV64 LD/SD words onto the register-file/RAM datapath and
//           shares the datapath read ports with a debug requester.
// Latency : accept at edge N -> EXEC cycle N+1, op_done cycle N+2, ready again N+3;
//           debug grant at edge N -> addresses cycle N+1, dbg_ack/data cycle N+2.
// Backpressure: in_ready low outside IDLE and whenever debug wins arbitration.
//
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   in_valid/in_instr/in_ready    instruction handshake (32-bit RV64 word)
//   op_done/op_err                completion pulse, error pulse for illegal words
//   dbg_req/dbg_ra/dbg_rb         debug read request, held until dbg_ack
//   dbg_ack/dbg_rdata_a/b         debug completion pulse and captured read data
//   dp_*                          datapath controls (registered) and read data in
//   ld_count/st_count             saturating committed-operation counters
module mem_op_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [31:0]      in_instr,
    output logic             in_ready,
    output logic             op_done,
    output logic             op_err,
    input  logic             dbg_req,
    input  logic [4:0]       dbg_ra,
    input  logic [4:0]       dbg_rb,
    output logic             dbg_ack,
    output logic [63:0]      dbg_rdata_a,
    output logic [63:0]      dbg_rdata_b,
    output logic             dp_enable,
    output logic             dp_load_store,
    output logic [4:0]       dp_a,
    output logic [4:0]       dp_b,
    output logic [4:0]       dp_w,
    output logic [63:0]      dp_din,
    input  logic [63:0]      dp_douta,
    input  logic [63:0]      dp_doutb,
    output logic [CNT_W-1:0] ld_count,
    output logic [CNT_W-1:0] st_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_DONE,
        S_DBG,
        S_DCAP
    } state_t;

    state_t           state_q, state_d;
    logic             last_dbg_q, last_dbg_d;   // 1 = debug was granted most recently
    logic             ill_q, ill_d;             // latched word was illegal
    logic             is_ld_q, is_ld_d;         // latched word was a load
    logic             dp_enable_q, dp_enable_d;
    logic             dp_ls_q, dp_ls_d;
    logic [4:0]       dp_a_q, dp_a_d;
    logic [4:0]       dp_b_q, dp_b_d;
    logic [4:0]       dp_w_q, dp_w_d;
    logic [63:0]      dp_din_q, dp_din_d;
    logic             op_done_q, op_done_d;
    logic             op_err_q, op_err_d;
    logic             dbg_ack_q, dbg_ack_d;
    logic [63:0]      dbg_rdata_a_q, dbg_rdata_a_d;
    logic [63:0]      dbg_rdata_b_q, dbg_rdata_b_d;
    logic [CNT_W-1:0] ld_count_q, ld_count_d;
    logic [CNT_W-1:0] st_count_q, st_count_d;

    // Decode of the presented word
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;
    logic        dec_ld, dec_sd;
    logic [63:0] imm_ld, imm_sd;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign rd     = in_instr[11:7];
    assign rs1    = in_instr[19:15];
    assign rs2    = in_instr[24:20];
    assign dec_ld = (opcode == 7'b0000011) && (funct3 == 3'b011);
    assign dec_sd = (opcode == 7'b0100011) && (funct3 == 3'b011);
    assign imm_ld = {{52{in_instr[31]}}, in_instr[31:20]};
    assign imm_sd = {{52{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};

    // Debug wins when it is alone, or on a tie when the instruction went last.
    logic dbg_win;
    assign dbg_win  = dbg_req && (!in_valid || !last_dbg_q);
    // Gated by rst_n so the handshake is closed for the whole reset interval.
    assign in_ready = rst_n && (state_q == S_IDLE) && !dbg_win;

    always_comb begin
        state_d       = state_q;
        last_dbg_d    = last_dbg_q;
        ill_d         = ill_q;
        is_ld_d       = is_ld_q;
        dp_enable_d   = 1'b0;
        dp_ls_d       = dp_ls_q;
        dp_a_d        = dp_a_q;
        dp_b_d        = dp_b_q;
        dp_w_d        = dp_w_q;
        dp_din_d      = dp_din_q;
        op_done_d     = 1'b0;
        op_err_d      = 1'b0;
        dbg_ack_d     = 1'b0;
        dbg_rdata_a_d = dbg_rdata_a_q;
        dbg_rdata_b_d = dbg_rdata_b_q;
        ld_count_d    = ld_count_q;
        st_count_d    = st_count_q;

        unique case (state_q)
            S_IDLE: begin
                if (dbg_win) begin
                    state_d    = S_DBG;
                    last_dbg_d = 1'b1;
                    dp_a_d     = dbg_ra;
                    dp_b_d     = dbg_rb;
                end else if (in_valid) begin
                    state_d    = S_EXEC;
                    last_dbg_d = 1'b0;
                    ill_d      = !(dec_ld || dec_sd);
                    is_ld_d    = dec_ld;
                    // Illegal words leave the datapath fields untouched.
                    if (dec_ld) begin
                        dp_ls_d     = 1'b1;
                        dp_a_d      = 5'd0;
                        dp_b_d      = rs1;
                        dp_w_d      = rd;
                        dp_din_d    = imm_ld;
                        dp_enable_d = (rd != 5'd0);   // x0 is never written
                    end else if (dec_sd) begin
                        dp_ls_d     = 1'b0;
                        dp_a_d      = rs2;
                        dp_b_d      = rs1;
                        dp_w_d      = 5'd0;
                        dp_din_d    = imm_sd;
                        dp_enable_d = 1'b1;
                    end
                end
            end
            S_EXEC: begin
                // Completion flags and counters are set here so they appear
                // together during the DONE cycle.
                state_d   = S_DONE;
                op_done_d = 1'b1;
                op_err_d  = ill_q;
                if (!ill_q && is_ld_q && (ld_count_q != {CNT_W{1'b1}}))
                    ld_count_d = ld_count_q + CNT_W'(1);
                if (!ill_q && !is_ld_q && (st_count_q != {CNT_W{1'b1}}))
                    st_count_d = st_count_q + CNT_W'(1);
            end
            S_DONE: state_d = S_IDLE;
            S_DBG: begin
                state_d       = S_DCAP;
                dbg_ack_d     = 1'b1;
                dbg_rdata_a_d = dp_douta;
                dbg_rdata_b_d = dp_doutb;
            end
            S_DCAP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            last_dbg_q    <= 1'b1;
            ill_q         <= 1'b0;
            is_ld_q       <= 1'b0;
            dp_enable_q   <= 1'b0;
            dp_ls_q       <= 1'b0;
            dp_a_q        <= 5'd0;
            dp_b_q        <= 5'd0;
            dp_w_q        <= 5'd0;
            dp_din_q      <= 64'd0;
            op_done_q     <= 1'b0;
            op_err_q      <= 1'b0;
            dbg_ack_q     <= 1'b0;
            dbg_rdata_a_q <= 64'd0;
            dbg_rdata_b_q <= 64'd0;
            ld_count_q    <= '0;
            st_count_q    <= '0;
        end else begin
            state_q       <= state_d;
            last_dbg_q    <= last_dbg_d;
            ill_q         <= ill_d;
            is_ld_q       <= is_ld_d;
            dp_enable_q   <= dp_enable_d;
            dp_ls_q       <= dp_ls_d;
            dp_a_q        <= dp_a_d;
            dp_b_q        <= dp_b_d;
            dp_w_q        <= dp_w_d;
            dp_din_q      <= dp_din_d;
            op_done_q     <= op_done_d;
            op_err_q      <= op_err_d;
            dbg_ack_q     <= dbg_ack_d;
            dbg_rdata_a_q <= dbg_rdata_a_d;
            dbg_rdata_b_q <= dbg_rdata_b_d;
            ld_count_q    <= ld_count_d;
            st_count_q    <= st_count_d;
        end
    end

    assign op_done       = op_done_q;
    assign op_err        = op_err_q;
    assign dbg_ack       = dbg_ack_q;
    assign dbg_rdata_a   = dbg_rdata_a_q;
    assign dbg_rdata_b   = dbg_rdata_b_q;
    assign dp_enable     = dp_enable_q;
    assign dp_load_store = dp_ls_q;
    assign dp_a          = dp_a_q;
    assign dp_b          = dp_b_q;
    assign dp_w          = dp_w_q;
    assign dp_din        = dp_din_q;
    assign ld_count      = ld_count_q;
    assign st_count      = st_count_q;

endmodule

// File: tb/tb_mem_op_sequencer.sv
module tb_mem_op_sequencer;

    localparam int CNT_W = 16;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic [31:0]      in_instr;
    logic             in_ready;
    logic             op_done;
    logic             op_err;
    logic             dbg_req;
    logic [4:0]       dbg_ra;
    logic [4:0]       dbg_rb;
    logic             dbg_ack;
    logic [63:0]      dbg_rdata_a;
    logic [63:0]      dbg_rdata_b;
    logic             dp_enable;
    logic             dp_load_store;
    logic [4:0]       dp_a;
    logic [4:0]       dp_b;
    logic [4:0]       dp_w;
    logic [63:0]      dp_din;
    logic [63:0]      dp_douta;
    logic [63:0]      dp_doutb;
    logic [CNT_W-1:0] ld_count;
    logic [CNT_W-1:0] st_count;

    mem_op_sequencer #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
        .op_done(op_done), .op_err(op_err),
        .dbg_req(dbg_req), .dbg_ra(dbg_ra), .dbg_rb(dbg_rb),
        .dbg_ack(dbg_ack), .dbg_rdata_a(dbg_rdata_a), .dbg_rdata_b(dbg_rdata_b),
        .dp_enable(dp_enable), .dp_load_store(dp_load_store),
        .dp_a(dp_a), .dp_b(dp_b), .dp_w(dp_w), .dp_din(dp_din),
        .dp_douta(dp_douta), .dp_doutb(dp_doutb),
        .ld_count(ld_count), .st_count(st_count)
    );

    // Register-file model behind the read ports
    logic [63:0] regs [32];
    assign dp_douta = regs[dp_a];
    assign dp_doutb = regs[dp_b];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] instr;
        logic        en;
        logic        ls;
        logic [4:0]  a;
        logic [4:0]  b;
        logic [4:0]  w;
        logic [63:0] din;
        logic        err;
        logic        chk_fields;
        logic        is_ld;
        logic        is_st;
    } vec_t;

    typedef struct {
        logic             err;
        logic [CNT_W-1:0] ld;
        logic [CNT_W-1:0] st;
        logic             chk_gap;
    } sb_t;

    vec_t tab [7];
    sb_t  sb [$];
    logic [CNT_W-1:0] exp_ld = '0;
    logic [CNT_W-1:0] exp_st = '0;
    int last_done_cyc = 0;

    // Completion monitor: every op_done must match the oldest accepted word.
    always @(negedge clk) begin
        if (op_done) begin
            if (sb.size() == 0) begin
                chk("unexpected_op_done", 64'(op_done), 64'd0);
            end else begin
                sb_t e;
                e = sb.pop_front();
                chk("done_op_err", 64'(op_err), 64'(e.err));
                chk("done_ld_count", 64'(ld_count), 64'(e.ld));
                chk("done_st_count", 64'(st_count), 64'(e.st));
                chk("done_dp_enable", 64'(dp_enable), 64'd0);
                if (e.chk_gap) chk("done_gap", 64'(cyc - last_done_cyc), 64'd3);
            end
            last_done_cyc = cyc;
        end
    end

    task automatic push_expected(input vec_t v, input logic gap);
        sb_t e;
        if (v.is_ld) exp_ld = exp_ld + 1'b1;
        if (v.is_st) exp_st = exp_st + 1'b1;
        e.err = v.err; e.ld = exp_ld; e.st = exp_st; e.chk_gap = gap;
        sb.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge inside the EXEC cycle.
    task automatic send(input vec_t v, input logic gap);
        logic ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_instr = v.instr;
        for (int t = 0; t < 20; t++) begin
            #1;
            if (in_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) begin
            chk("accept_timeout", 64'(ok), 64'd1);
            in_valid = 1'b0;
            return;
        end
        push_expected(v, gap);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("exec_enable", 64'(dp_enable), 64'(v.en));
        if (v.chk_fields) begin
            chk("exec_ls", 64'(dp_load_store), 64'(v.ls));
            chk("exec_a", 64'(dp_a), 64'(v.a));
            chk("exec_b", 64'(dp_b), 64'(v.b));
            chk("exec_w", 64'(dp_w), 64'(v.w));
            chk("exec_din", dp_din, v.din);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        sb.delete();
        exp_ld = '0;
        exp_st = '0;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_grant;
        logic [4:0] wait_i;

        for (int i = 0; i < 32; i++) regs[i] = 64'hDEAD_0000_0000_0000 + 64'(i) * 64'h0101_0101;

        //            instr          en    ls    a      b       w      din                       err   chk   ld    st
        tab[0] = '{32'h00433123, 1'b1, 1'b0, 5'd4,  5'd6,  5'd0, 64'd2,                    1'b0, 1'b1, 1'b0, 1'b1};
        tab[1] = '{32'h0036B103, 1'b1, 1'b1, 5'd0,  5'd13, 5'd2, 64'd3,                    1'b0, 1'b1, 1'b1, 1'b0};
        tab[2] = '{32'hFF80B283, 1'b1, 1'b1, 5'd0,  5'd1,  5'd5, 64'hFFFF_FFFF_FFFF_FFF8,  1'b0, 1'b1, 1'b1, 1'b0};
        tab[3] = '{32'h00000013, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0, 64'd0,                    1'b1, 1'b0, 1'b0, 1'b0};
        tab[4] = '{32'h00003003, 1'b0, 1'b1, 5'd0,  5'd0,  5'd0, 64'd0,                    1'b0, 1'b1, 1'b1, 1'b0};
        tab[5] = '{32'h81FFB023, 1'b1, 1'b0, 5'd31, 5'd31, 5'd0, 64'hFFFF_FFFF_FFFF_F800,  1'b0, 1'b1, 1'b0, 1'b1};
        tab[6] = '{32'h00002003, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0, 64'd0,                    1'b1, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; in_instr = 32'd0;
        dbg_req = 1'b0; dbg_ra = 5'd0; dbg_rb = 5'd0;

        // Reset values
        repeat (2) @(negedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_dp_ctl", 64'({dp_enable, dp_load_store, dp_a, dp_b, dp_w}), 64'd0);
        chk("rst_dp_din", dp_din, 64'd0);
        chk("rst_flags", 64'({op_done, op_err, dbg_ack}), 64'd0);
        chk("rst_dbg_rdata", dbg_rdata_a | dbg_rdata_b, 64'd0);
        chk("rst_counts", 64'({ld_count, st_count}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk); #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Both requesters asserted from reset: instruction first, then alternate.
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b1; in_instr = tab[1].instr;
        dbg_req = 1'b1; dbg_ra = 5'd2; dbg_rb = 5'd3;
        repeat (2) @(negedge clk);
        sb.delete(); exp_ld = '0; exp_st = '0;
        rst_n = 1'b1;
        n_grant = 0;
        for (int c = 0; c < 60 && n_grant < 8; c++) begin
            #1;
            if (in_valid && in_ready) begin
                chk("arb_order_instr", 64'(n_grant % 2), 64'd0);
                push_expected(tab[1], 1'b0);
                n_grant++;
            end
            if (dbg_ack) begin
                chk("arb_order_dbg", 64'(n_grant % 2), 64'd1);
                chk("arb_dbg_a", dbg_rdata_a, regs[2]);
                chk("arb_dbg_b", dbg_rdata_b, regs[3]);
                n_grant++;
            end
            if (n_grant < 8) @(negedge clk);
        end
        chk("arb_grants", 64'(n_grant), 64'd8);
        in_valid = 1'b0; dbg_req = 1'b0;
        repeat (6) @(negedge clk);
        chk("arb_sb_drained", 64'(sb.size()), 64'd0);
        chk("arb_ld_count", 64'(ld_count), 64'd4);

        // Table-driven instruction vectors
        do_reset();
        for (int i = 0; i < 7; i++) send(tab[i], (i == 1));
        repeat (6) @(negedge clk);
        chk("tab_sb_drained", 64'(sb.size()), 64'd0);
        chk("tab_ld_count", 64'(ld_count), 64'd3);
        chk("tab_st_count", 64'(st_count), 64'd2);

        // Lone debug read: wins in the same cycle, fixed latency, data held
        dbg_ra = 5'd2; dbg_rb = 5'd3; dbg_req = 1'b1;
        #1 chk("dbg_in_ready_low", 64'(in_ready), 64'd0);
        @(negedge clk);
        chk("dbg_addr", 64'({dp_a, dp_b}), 64'({5'd2, 5'd3}));
        chk("dbg_enable", 64'(dp_enable), 64'd0);
        @(negedge clk);
        chk("dbg_ack", 64'(dbg_ack), 64'd1);
        chk("dbg_rdata_a", dbg_rdata_a, regs[2]);
        chk("dbg_rdata_b", dbg_rdata_b, regs[3]);
        dbg_req = 1'b0;
        @(negedge clk);
        chk("dbg_ack_pulse", 64'(dbg_ack), 64'd0);
        chk("dbg_hold_b", dbg_rdata_b, regs[3]);

        // Reset during EXEC of a store abandons it
        send(tab[0], 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_enable", 64'(dp_enable), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd0);
        sb.delete(); exp_ld = '0; exp_st = '0;
        rst_n = 1'b1;
        wait_i = 5'd0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            if (op_done) wait_i = wait_i + 5'd1;
            if (c == 0) chk("midrst_ready_after", 64'(in_ready), 64'd1);
        end
        chk("midrst_no_done", 64'(wait_i), 64'd0);
        chk("midrst_st_count", 64'(st_count), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
